// File: rtl/edge_detect_pkg.sv
// Shared constants for the multi-channel edge detector: edge-select encodings
// and filter counter sizing.
package edge_detect_pkg;

  localparam logic [1:0] EDGE_OFF  = 2'b00;
  localparam logic [1:0] EDGE_RISE = 2'b01;
  localparam logic [1:0] EDGE_FALL = 2'b10;
  localparam logic [1:0] EDGE_BOTH = 2'b11;

  localparam int FILTER_MAX = 15;
  localparam int FC_W       = 4;

  // True when a level transition in the given direction is selected by mode.
  function automatic logic edge_qualifies(logic [1:0] mode, logic rising);
    if (rising) return (mode == EDGE_RISE) || (mode == EDGE_BOTH);
    else        return (mode == EDGE_FALL) || (mode == EDGE_BOTH);
  endfunction

endpackage

// File: rtl/edge_detect_multi_if.sv
// Bus bundle between the edge detector and its client: raw inputs and
// controls in, per-channel level/strobe/flags/interval out.
interface edge_detect_multi_if #(
  parameter int CHANNELS       = 4,
  parameter int INTERVAL_WIDTH = 16
);
  logic [CHANNELS-1:0]                data;
  logic [2*CHANNELS-1:0]              mode;
  logic [CHANNELS-1:0]                ack;
  logic [CHANNELS-1:0]                level;
  logic [CHANNELS-1:0]                strobe;
  logic [CHANNELS-1:0]                pending;
  logic [CHANNELS-1:0]                overflow;
  logic [CHANNELS*INTERVAL_WIDTH-1:0] interval;

  modport master (output data, mode, ack,
                  input  level, strobe, pending, overflow, interval);
  modport slave  (input  data, mode, ack,
                  output level, strobe, pending, overflow, interval);
endinterface

// File: rtl/edge_detect_channel.sv
// One channel: synchroniser, glitch filter, edge strobe, sticky
// pending/overflow flags and edge-to-edge interval measurement.
module edge_detect_channel
  import edge_detect_pkg::*;
#(
  parameter int SYNC_STAGES    = 2,
  parameter int FILTER_CYCLES  = 3,
  parameter int INTERVAL_WIDTH = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      din,
  input  logic [1:0]                mode,
  input  logic                      ack,
  output logic                      level,
  output logic                      strobe,
  output logic                      pending,
  output logic                      overflow,
  output logic [INTERVAL_WIDTH-1:0] interval
);

  localparam logic [FC_W-1:0]           FC_LAST = FC_W'(FILTER_CYCLES - 1);
  localparam logic [INTERVAL_WIDTH-1:0] RC_MAX  = '1;

  logic [SYNC_STAGES-1:0]    sync_q;
  logic [FC_W-1:0]           fc;
  logic [INTERVAL_WIDTH-1:0] rc;
  logic                      s;
  logic                      accept;
  logic                      fire;
  logic [INTERVAL_WIDTH-1:0] rc_inc;

  assign s      = sync_q[SYNC_STAGES-1];
  assign accept = (s != level) && (fc == FC_LAST);
  // Mode is only consulted at the moment a new level is accepted.
  assign fire   = accept && edge_qualifies(mode, s);
  assign rc_inc = (rc == RC_MAX) ? RC_MAX : rc + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q   <= '0;
      fc       <= '0;
      level    <= 1'b0;
      strobe   <= 1'b0;
      pending  <= 1'b0;
      overflow <= 1'b0;
      rc       <= '0;
      interval <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], din};

      if (s == level) begin
        fc <= '0;
      end else if (accept) begin
        level <= s;
        fc    <= '0;
      end else begin
        fc <= fc + 1'b1;
      end

      strobe <= fire;

      if (fire) begin
        interval <= rc_inc;
        rc       <= '0;
      end else begin
        rc <= rc_inc;
      end

      // Flags react to the strobe already on the output.
      if (strobe && ack) begin
        pending  <= 1'b1;
        overflow <= 1'b0;
      end else if (strobe && pending) begin
        overflow <= 1'b1;
      end else if (strobe) begin
        pending <= 1'b1;
      end else if (ack) begin
        pending  <= 1'b0;
        overflow <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/edge_detect_multi.sv
// Multi-channel edge detector: CHANNELS independent copies of the per-channel
// detector, gathered onto one interface.
module edge_detect_multi
  import edge_detect_pkg::*;
#(
  parameter int CHANNELS       = 4,
  parameter int SYNC_STAGES    = 2,
  parameter int FILTER_CYCLES  = 3,
  parameter int INTERVAL_WIDTH = 16
) (
  input  logic                clk,
  input  logic                rst,
  edge_detect_multi_if.slave  bus
);

  logic [CHANNELS-1:0]                     level_w;
  logic [CHANNELS-1:0]                     strobe_w;
  logic [CHANNELS-1:0]                     pending_w;
  logic [CHANNELS-1:0]                     overflow_w;
  logic [CHANNELS-1:0][INTERVAL_WIDTH-1:0] interval_w;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    edge_detect_channel #(
      .SYNC_STAGES    (SYNC_STAGES),
      .FILTER_CYCLES  (FILTER_CYCLES),
      .INTERVAL_WIDTH (INTERVAL_WIDTH)
    ) u_ch (
      .clk      (clk),
      .rst      (rst),
      .din      (bus.data[i]),
      .mode     (bus.mode[2*i +: 2]),
      .ack      (bus.ack[i]),
      .level    (level_w[i]),
      .strobe   (strobe_w[i]),
      .pending  (pending_w[i]),
      .overflow (overflow_w[i]),
      .interval (interval_w[i])
    );
  end

  assign bus.level    = level_w;
  assign bus.strobe   = strobe_w;
  assign bus.pending  = pending_w;
  assign bus.overflow = overflow_w;
  assign bus.interval = interval_w;

endmodule

// File: doc/edge_detect_multi.md
Name: edge_detect_multi

Overview:
- Multi-channel successor to the single-bit XOR edge detector.
- Per channel: synchronises an asynchronous input, rejects glitches shorter than a programmable width, and emits a one-cycle strobe on the selected edge type (rising, falling or both).
- Per channel it also keeps a sticky pending/overflow flag pair with acknowledge, and measures the interval between qualifying edges.
- Intended for drive status lines and read-data timing in the controller datapath.

Parameters:
- CHANNELS, 4: number of independent input channels (1..32).
- SYNC_STAGES, 2: synchroniser flops per channel (>=2).
- FILTER_CYCLES, 3: consecutive cycles a new level must persist before acceptance (1..15; 1 = no filtering).
- INTERVAL_WIDTH, 16: width of each interval measurement (4..32).

Ports:
- clk  in  1  system clock
- rst  in  1  reset; synchronous, active-high
- data  in  CHANNELS  asynchronous inputs
- mode  in  2*CHANNELS  per-channel edge select: bits [2i+1:2i] = 00 off, 01 rising, 10 falling, 11 both
- ack  in  CHANNELS  per-channel clear of pending/overflow
- level  out  CHANNELS  filtered, synchronised level
- strobe  out  CHANNELS  one-cycle pulse on qualifying edge
- pending  out  CHANNELS  sticky event flag
- overflow  out  CHANNELS  sticky lost-event flag
- interval  out  CHANNELS*INTERVAL_WIDTH  clock edges between the last two qualifying edges; channel i at [i*W +: W]

Behaviour:
- Reset values (all take effect on the first clk edge with rst=1): sync chain, level, strobe, pending, overflow, filter counters, run counters and interval all 0.
- Reset has priority over every other input.
- Reset mid-operation discards any partially filtered transition.
- Synchroniser: plain flop chain. Output s changes after edge E0+SYNC_STAGES-1, where E0 is the first edge sampling the new data value.
- Filter, per channel, with counter fc of 4 bits:
  - If s == level: fc <= 0.
  - Else if fc == FILTER_CYCLES-1: level <= s and fc <= 0.
  - Else: fc <= fc+1.
  - A pulse on s shorter than FILTER_CYCLES cycles never changes level.
- Latency: level changes after edge E0+SYNC_STAGES+FILTER_CYCLES-1. Defaults: E0+4.
- Strobe:
  - Registered, and changes on the same edge as level.
  - Qualifying edge = level rising with mode 01 or 11, or level falling with mode 10 or 11.
  - Strobe is high exactly one cycle per accepted transition.
  - Mode 00 never strobes.
  - Changing mode alone never generates a strobe; a new mode applies to the next level change.
- Level tracks the input in all modes, including 00.
- Pending/overflow, per channel, evaluated in this priority order:
  - strobe=1 and ack=1: pending stays 1, overflow <= 0.
  - strobe=1, ack=0, pending=1: overflow <= 1.
  - strobe=1, ack=0, pending=0: pending <= 1.
  - strobe=0, ack=1: pending <= 0, overflow <= 0.
  - ack with pending=0 has no effect beyond clearing overflow.
- Interval:
  - Run counter rc increments every edge and saturates at 2^W-1.
  - On the edge where strobe is generated: interval <= min(rc+1, 2^W-1) and rc <= 0.
  - Strobes N edges apart therefore report interval = N.
  - The first strobe after reset reports edges since reset deassertion (saturated).
  - When mode is 00, interval holds its value and rc keeps running.
- Consequence of level resetting to 0: an input held high through reset yields one rising-edge strobe at normal latency after rst drops, when enabled.
- Channels are fully independent; simultaneous events on different channels are all reported in the same cycle.

Decomposition:
- Package edge_detect_pkg holds:
  - mode constants EDGE_OFF=2'b00, EDGE_RISE=2'b01, EDGE_FALL=2'b10, EDGE_BOTH=2'b11;
  - max FILTER_CYCLES constant (15);
  - filter counter width (4).
- One sub-module, edge_detect_channel, is natural. It contains the synchroniser, filter, strobe, pending/overflow and interval logic for one channel, and the top generates CHANNELS instances of it.

Test Plan:
- Rising edge, defaults, mode=01 on ch0: data[0] 0->1 before edge E0 -> level[0]/strobe[0] rise after E0+4; strobe is high 1 cycle; pending[0]=1; other channels idle.
- Glitch rejection, FILTER_CYCLES=3: data[1] high for 2 cycles then low -> level, strobe and pending stay 0. A 3-cycle pulse -> strobe on the rising edge only (mode 01).
- Both-edge mode=11: toggle data[2] every 20 cycles -> strobe on each toggle; interval[2] reads 20 from the second strobe onward.
- Overflow and ack: two strobes without ack -> pending=1, overflow=1. Ack alone clears both. Strobe coincident with ack -> pending=1, overflow=0.
- Saturation, INTERVAL_WIDTH=4: strobes 40 cycles apart -> interval=15. Mode 00 -> no strobe, level still toggles, interval unchanged.
- Reset mid-filter: assert rst 2 cycles after s changes -> all outputs 0 next edge. With data held high after rst drops -> single rising strobe at E+4.
